// File: rtl/rc4_keystream_ctrl_if.sv
// Bus between the RC4 sequencer, its key register file, the S-box SRAM and the
// downstream XOR datapath.
interface rc4_keystream_ctrl_if #(
  parameter int KEY_IDX_BITS = 4
);
  logic                    start;
  logic [KEY_IDX_BITS-1:0] key_len_m1;
  logic [KEY_IDX_BITS-1:0] key_idx;
  logic [7:0]              key_byte;
  logic [7:0]              sbox_addr;
  logic [7:0]              sbox_wdata;
  logic                    sbox_we;
  logic [7:0]              sbox_rdata;
  // Keystream handshake: ks_req is taken only while ready is high (or while it
  // is still held high as a chained request at the end of a byte); each taken
  // request yields exactly one single-cycle ks_valid pulse, and ks_byte holds
  // its value until the next pulse. There is no backpressure on ks_valid.
  logic                    ks_req;
  logic                    ks_valid;
  logic [7:0]              ks_byte;
  logic                    ready;
  logic                    busy;
  logic [3:0]              state_dbg;

  modport master (
    input  start, key_len_m1, key_byte, sbox_rdata, ks_req,
    output key_idx, sbox_addr, sbox_wdata, sbox_we,
    output ks_valid, ks_byte, ready, busy, state_dbg
  );

  modport slave (
    output start, key_len_m1, key_byte, sbox_rdata, ks_req,
    input  key_idx, sbox_addr, sbox_wdata, sbox_we,
    input  ks_valid, ks_byte, ready, busy, state_dbg
  );
endinterface

// File: rtl/rc4_keystream_ctrl.sv
// RC4 sequencer: S-box init, key scheduling and on-demand keystream over a
// single-port 256x8 SRAM. Optional keystream discard after KSA: RC4_DROP_EN.
module rc4_keystream_ctrl #(
  parameter int KEY_IDX_BITS = 4,
  parameter int DROP_N       = 256
) (
  input  logic                 clk,
  input  logic                 n_rst,
  rc4_keystream_ctrl_if.master bus
);

`ifdef RC4_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [9:0] DROP_LOAD = 10'(DROP_N);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    KSA_RDI  = 4'd2,
    KSA_RDJ  = 4'd3,
    KSA_WRI  = 4'd4,
    KSA_WRJ  = 4'd5,
    READY    = 4'd6,
    PRGA_RDI = 4'd7,
    PRGA_RDJ = 4'd8,
    PRGA_WRI = 4'd9,
    PRGA_WRJ = 4'd10,
    PRGA_RDK = 4'd11,
    PRGA_OUT = 4'd12
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              i_q;
  logic [7:0]              j_q;
  logic [7:0]              si_q;
  logic [7:0]              sj_q;
  logic [KEY_IDX_BITS-1:0] kidx_q;
  logic                    drop_q;
  logic [9:0]              drop_cnt_q;
  logic                    ks_valid_q;
  logic [7:0]              ks_byte_q;

  logic [7:0]              j_ksa;
  logic [7:0]              j_prga;
  logic [7:0]              addr_c;
  logic [7:0]              wdata_c;
  logic                    we_c;
  logic                    last_i;
  logic                    last_drop;

  // New j is formed from the read data arriving this cycle, so the address of
  // S[j] can be presented without an extra cycle.
  assign j_ksa     = j_q + bus.sbox_rdata + bus.key_byte;
  assign j_prga    = j_q + bus.sbox_rdata;
  assign last_i    = (i_q == 8'hFF);
  assign last_drop = (drop_cnt_q == 10'd1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.start) state_nxt = INIT;
      INIT:     if (last_i) state_nxt = KSA_RDI;
      KSA_RDI:  state_nxt = KSA_RDJ;
      KSA_RDJ:  state_nxt = KSA_WRI;
      KSA_WRI:  state_nxt = KSA_WRJ;
      KSA_WRJ: begin
        if (!last_i)      state_nxt = KSA_RDI;
        else if (DROP_EN) state_nxt = PRGA_RDI;
        else              state_nxt = READY;
      end
      READY: begin
        if (bus.start)       state_nxt = INIT;
        else if (bus.ks_req) state_nxt = PRGA_RDI;
      end
      PRGA_RDI: state_nxt = PRGA_RDJ;
      PRGA_RDJ: state_nxt = PRGA_WRI;
      PRGA_WRI: state_nxt = PRGA_WRJ;
      PRGA_WRJ: state_nxt = PRGA_RDK;
      PRGA_RDK: state_nxt = PRGA_OUT;
      // A request still held at the end of a byte chains straight into the next
      // one, giving one byte every six cycles.
      PRGA_OUT: begin
        if (drop_q)          state_nxt = last_drop ? READY : PRGA_RDI;
        else if (bus.ks_req) state_nxt = PRGA_RDI;
        else                 state_nxt = READY;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_c  = 8'h00;
    wdata_c = 8'h00;
    we_c    = 1'b0;
    case (state)
      INIT: begin
        we_c    = 1'b1;
        addr_c  = i_q;
        wdata_c = i_q;
      end
      KSA_RDI, PRGA_RDI: addr_c = i_q;
      KSA_RDJ:           addr_c = j_ksa;
      PRGA_RDJ:          addr_c = j_prga;
      KSA_WRI, PRGA_WRI: begin
        we_c    = 1'b1;
        addr_c  = i_q;
        wdata_c = bus.sbox_rdata;
      end
      // The swap writes back the captured S[i], so i == j needs no special case.
      KSA_WRJ, PRGA_WRJ: begin
        we_c    = 1'b1;
        addr_c  = j_q;
        wdata_c = si_q;
      end
      PRGA_RDK:          addr_c = si_q + sj_q;
      default: begin
        addr_c  = 8'h00;
        wdata_c = 8'h00;
        we_c    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      i_q        <= 8'h00;
      j_q        <= 8'h00;
      si_q       <= 8'h00;
      sj_q       <= 8'h00;
      kidx_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 10'd0;
    end else begin
      case (state)
        IDLE: if (bus.start) i_q <= 8'h00;
        INIT: begin
          i_q <= i_q + 8'd1;
          if (last_i) begin
            j_q    <= 8'h00;
            kidx_q <= '0;
          end
        end
        KSA_RDJ: begin
          si_q <= bus.sbox_rdata;
          j_q  <= j_ksa;
        end
        KSA_WRI: sj_q <= bus.sbox_rdata;
        KSA_WRJ: begin
          kidx_q <= (kidx_q == bus.key_len_m1) ? '0 : kidx_q + 1'b1;
          if (last_i) begin
            j_q <= 8'h00;
            // Entering the discard run behaves like a request taken in READY.
            i_q <= DROP_EN ? 8'h01 : 8'h00;
            if (DROP_EN) begin
              drop_q     <= 1'b1;
              drop_cnt_q <= DROP_LOAD;
            end
          end else begin
            i_q <= i_q + 8'd1;
          end
        end
        READY: begin
          if (bus.start)       i_q <= 8'h00;
          else if (bus.ks_req) i_q <= i_q + 8'd1;
        end
        PRGA_RDJ: begin
          si_q <= bus.sbox_rdata;
          j_q  <= j_prga;
        end
        PRGA_WRI: sj_q <= bus.sbox_rdata;
        PRGA_OUT: begin
          if (drop_q) begin
            if (last_drop) begin
              drop_q <= 1'b0;
            end else begin
              drop_cnt_q <= drop_cnt_q - 10'd1;
              i_q        <= i_q + 8'd1;
            end
          end else if (bus.ks_req) begin
            i_q <= i_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ks_valid_q <= 1'b0;
      ks_byte_q  <= 8'h00;
    end else begin
      ks_valid_q <= (state == PRGA_OUT) && !drop_q;
      if ((state == PRGA_OUT) && !drop_q) begin
        ks_byte_q <= bus.sbox_rdata;
      end
    end
  end

  assign bus.sbox_addr  = addr_c;
  assign bus.sbox_wdata = wdata_c;
  assign bus.sbox_we    = we_c;
  assign bus.key_idx    = kidx_q;
  assign bus.ks_valid   = ks_valid_q;
  assign bus.ks_byte    = ks_byte_q;
  assign bus.ready      = (state == READY);
  assign bus.busy       = (state != IDLE) && (state != READY);
  assign bus.state_dbg  = state;

endmodule
